// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal register with hold, shift right, shift left, parallel load, sync reset/set and a wrap pulse every WIDTH shifts
//   clk, rst (sync, active-high), st (sync set to all ones), en, mode (00 hold, 01 right, 10 left, 11 load)
//   sin_r/sin_l serial fills, d load data; q contents, sout_r/sout_l end bits, cnt shift count, done wrap pulse
module univ_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit              ROTATE    = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         st,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic                         sin_r,
  input  logic                         sin_l,
  input  logic [WIDTH-1:0]             d,
  output logic [WIDTH-1:0]             q,
  output logic                         sout_r,
  output logic                         sout_l,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         done
);
  localparam int CW = $clog2(WIDTH+1);
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic             w_shift;
  logic             w_load;
  logic             w_wrap;
  logic             w_fill_r;
  logic             w_fill_l;
  logic [WIDTH-1:0] w_q_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  always_comb begin
    w_shift   = en & (mode == 2'b01 || mode == 2'b10);
    w_load    = en & (mode == 2'b11);
    w_wrap    = w_shift & (r_cnt == CW'(WIDTH-1));
    w_fill_r  = ROTATE ? r_q[0] : sin_r;
    w_fill_l  = ROTATE ? r_q[WIDTH-1] : sin_l;
    w_q_nxt   = !en            ? r_q :
                mode == 2'b01  ? {w_fill_r, r_q[WIDTH-1:1]} :
                mode == 2'b10  ? {r_q[WIDTH-2:0], w_fill_l} :
                mode == 2'b11  ? d : r_q;
    w_cnt_nxt = (w_load || w_wrap) ? '0 : w_shift ? r_cnt + 1'b1 : r_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= RESET_VAL;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (st) begin
      r_q    <= '1;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= w_wrap;
    end
  end
  assign q      = r_q;
  assign cnt    = r_cnt;
  assign done   = r_done;
  assign sout_r = r_q[0];
  assign sout_l = r_q[WIDTH-1];
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register that generalises the single-bit D flip-flop with reset/set to a WIDTH-bit register.
- Modes: hold, shift right, shift left (serial or rotate fill), parallel load.
- Synchronous reset and set.
- Shift counter pulses `done` after every WIDTH shifts.
- Used as a serialiser/deserialiser and general staging register in datapath blocks.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q by rst.
- ROTATE, 0, 0 = shift fill from serial inputs; 1 = shifted-out bit re-enters at the opposite end (serial inputs ignored).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- st  input  1  synchronous, active-high set; q <= all ones.
- en  input  1  operation enable; 0 = hold regardless of mode.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  input  1  serial input entering at the MSB on shift right.
- sin_l  input  1  serial input entering at the LSB on shift left.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout_r  output  1  equals q[0] (combinational from q).
- sout_l  output  1  equals q[WIDTH-1] (combinational from q).
- cnt  output  $clog2(WIDTH+1)  number of shifts since the last load, reset, set or wrap.
- done  output  1  one-cycle pulse, registered.

Behaviour:
- One clock and synchronous reset only. No asynchronous paths; rst and st are sampled only at the clk rising edge.
- Priority per edge: rst > st > (en & mode).
- rst=1: q <= RESET_VAL, cnt <= 0, done <= 0. These are the reset values of all registered outputs.
- st=1 (rst=0): q <= all ones, cnt <= 0, done <= 0.
- en=0 or mode=00: q and cnt hold; done <= 0.
- mode=01, shift right: q <= {fill, q[WIDTH-1:1]}.
  - fill = sin_r when ROTATE=0; fill = q[0] when ROTATE=1.
- mode=10, shift left: q <= {q[WIDTH-2:0], fill}.
  - fill = sin_l when ROTATE=0; fill = q[WIDTH-1] when ROTATE=1.
- mode=11, parallel load: q <= d, cnt <= 0, done <= 0.
- Shift counting:
  - Every executed shift (mode 01 or 10 with en=1) increments cnt.
  - When cnt == WIDTH-1 and a shift executes: cnt <= 0 and done <= 1 on that same edge. done is therefore visible in the cycle after the WIDTH-th shift.
  - done is 0 on every other edge; it never stays high two cycles unless a second wrap occurs.
  - Mixed left and right shifts all count toward the same cnt.
- Boundary conditions:
  - Mode change mid-sequence (e.g. right then left): cnt continues, no clear.
  - Load mid-sequence: cnt clears, no done pulse.
  - rst or st asserted mid-sequence: q per rst/st rule, cnt <= 0, done <= 0. A pending wrap is discarded even if cnt == WIDTH-1 with a shift requested.
  - rst and st both 1: rst wins; q = RESET_VAL.
  - ROTATE=1 and WIDTH shifts in one direction: q returns to its original value and done pulses.
  - cnt never exceeds WIDTH-1.
- Latency: q, cnt and done update one edge after the controlling inputs. sout_r/sout_l follow q with no extra delay.

Test Plan:
1. Reset and set priority: WIDTH=8, RESET_VAL=8'hA5. rst=1 for one edge → q=8'hA5, cnt=0, done=0. Then st=1, rst=0 → q=8'hFF. Then rst=1 and st=1 together → q=8'hA5.
2. Load then shift right: load d=8'h81; then 8 shifts right with sin_r=0.
   - q after each shift: 40, 20, 10, 08, 04, 02, 01, 00.
   - sout_r before each shift: 1, 0, 0, 0, 0, 0, 0, 1.
   - done=1 only in the cycle after the 8th shift; cnt back at 0.
3. Shift left with serial fill: q=8'h00; shift left with sin_l bit stream 1,0,1,1,0,0,1,0 (LSB entry) → q=8'hB2 after 8 shifts; done pulses once.
4. Rotate: ROTATE=1, load d=8'h3C, 8 shifts left → q=8'h3C and done=1. Then one right rotate → q=8'h1E, cnt=1.
5. Hold and interrupt:
   - Load 8'hF0, 5 shifts right with sin_r=1; then en=0 for 3 cycles → q=8'hFF and cnt=5 hold unchanged.
   - Then load d=8'h00 → cnt=0 and no done pulse.
   - Repeat with rst=1 at cnt=7 plus a shift request → q=RESET_VAL, done stays 0.
6. Mixed directions: from q=8'h01, 4 shifts left then 4 shifts right with fill 0 → q=8'h01 and done pulses after the 8th shift (the counter is shared across directions).
